// File: rtl/sprite_renderer.sv
// sprite_renderer
//   Erases and redraws the ship and enemy sprites on a 160x120 VGA frame
//   buffer. Each frame is a stream of single-pixel plots, one per clock.
//   The stream has four phases: erase ship, draw ship, erase enemy and
//   draw enemy. Erasing always happens at the previously drawn position,
//   so the screen never keeps stale sprite pixels.
//
// Ports
//   clk_i       system clock (50 MHz)
//   reset_i     asynchronous active-high reset
//   start_i     render request; only accepted while idle
//   user_x_i    ship left-edge x, latched when a request is accepted
//   enemy_x_i   enemy left-edge x, latched when a request is accepted
//   busy_o      high while a frame's pixels are being presented
//   done_o      one-cycle pulse after the last pixel of a frame
//   x_out_o     pixel x to the VGA adapter
//   y_out_o     pixel y to the VGA adapter
//   colour_o    pixel colour to the VGA adapter
//   plot_o      adapter write strobe; low for pixels clipped off the right edge
module sprite_renderer #(
  parameter int          SPRITE_W     = 8,
  parameter int          SPRITE_H     = 4,
  parameter int          SCREEN_W     = 160,
  parameter int          SHIP_Y       = 116,
  parameter int          ENEMY_Y      = 0,
  parameter logic [2:0]  SHIP_COLOUR  = 3'b010,
  parameter logic [2:0]  ENEMY_COLOUR = 3'b100
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] user_x_i,
  input  logic [7:0] enemy_x_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] x_out_o,
  output logic [6:0] y_out_o,
  output logic [2:0] colour_o,
  output logic       plot_o
);

  localparam int DXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int DYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [DXW-1:0] DX_LAST   = DXW'(SPRITE_W - 1);
  localparam logic [DYW-1:0] DY_LAST   = DYW'(SPRITE_H - 1);
  localparam logic [8:0]     SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [6:0]     SHIP_Y7   = 7'(SHIP_Y);
  localparam logic [6:0]     ENEMY_Y7  = 7'(ENEMY_Y);

  typedef enum logic [2:0] {
    IDLE,
    ERASE_SHIP,
    DRAW_SHIP,
    ERASE_ENEMY,
    DRAW_ENEMY
  } state_t;

  state_t         state_q, state_d;
  logic [DXW-1:0] dx_q, dx_d;
  logic [DYW-1:0] dy_q, dy_d;
  logic [7:0]     prevShipX_q, prevShipX_d;
  logic [7:0]     prevEnemyX_q, prevEnemyX_d;
  logic [7:0]     newShipX_q, newShipX_d;
  logic [7:0]     newEnemyX_q, newEnemyX_d;

  logic           busy_d, done_d, plot_d;
  logic [7:0]     x_d;
  logic [6:0]     y_d;
  logic [2:0]     colour_d;

  logic [7:0]     baseX;
  logic [6:0]     baseY;
  logic [2:0]     pixColour;
  logic [8:0]     xSum;
  logic           lastPixel;

  // The FSM state names the pixel about to be presented; the output
  // registers present it one cycle later. After the last pixel the FSM is
  // already back in IDLE while busy_o is still high, so busy_q doubles as
  // "last pixel still on the bus": it blocks a new start for that cycle
  // and triggers done on the following edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      dx_q         <= '0;
      dy_q         <= '0;
      prevShipX_q  <= '0;
      prevEnemyX_q <= '0;
      newShipX_q   <= '0;
      newEnemyX_q  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      plot_o       <= 1'b0;
      x_out_o      <= '0;
      y_out_o      <= '0;
      colour_o     <= '0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      prevShipX_q  <= prevShipX_d;
      prevEnemyX_q <= prevEnemyX_d;
      newShipX_q   <= newShipX_d;
      newEnemyX_q  <= newEnemyX_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      plot_o       <= plot_d;
      x_out_o      <= x_d;
      y_out_o      <= y_d;
      colour_o     <= colour_d;
    end
  end

  // Pixel source for the current phase: which x register, which row
  // band and which colour.
  always_comb begin
    baseX     = '0;
    baseY     = '0;
    pixColour = 3'b000;
    unique case (state_q)
      ERASE_SHIP:  begin baseX = prevShipX_q;  baseY = SHIP_Y7;  pixColour = 3'b000;       end
      DRAW_SHIP:   begin baseX = newShipX_q;   baseY = SHIP_Y7;  pixColour = SHIP_COLOUR;  end
      ERASE_ENEMY: begin baseX = prevEnemyX_q; baseY = ENEMY_Y7; pixColour = 3'b000;       end
      DRAW_ENEMY:  begin baseX = newEnemyX_q;  baseY = ENEMY_Y7; pixColour = ENEMY_COLOUR; end
      default:     begin baseX = '0;           baseY = '0;       pixColour = 3'b000;       end
    endcase
  end

  // The 9-bit sum keeps the carry so pixels past the right edge are
  // recognised and suppressed instead of wrapping onto the left side.
  assign xSum      = {1'b0, baseX} + 9'(dx_q);
  assign lastPixel = (dx_q == DX_LAST) && (dy_q == DY_LAST);

  // Next-state, counters and position bookkeeping.
  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    prevShipX_d  = prevShipX_q;
    prevEnemyX_d = prevEnemyX_q;
    newShipX_d   = newShipX_q;
    newEnemyX_d  = newEnemyX_q;

    if (state_q == IDLE) begin
      if (start_i && !busy_o) begin
        newShipX_d  = user_x_i;
        newEnemyX_d = enemy_x_i;
        dx_d        = '0;
        dy_d        = '0;
        state_d     = ERASE_SHIP;
      end
    end else begin
      if (dx_q == DX_LAST) begin
        dx_d = '0;
        if (dy_q == DY_LAST) dy_d = '0;
        else                 dy_d = dy_q + DYW'(1);
      end else begin
        dx_d = dx_q + DXW'(1);
      end

      if (lastPixel) begin
        unique case (state_q)
          ERASE_SHIP:  state_d = DRAW_SHIP;
          DRAW_SHIP:   state_d = ERASE_ENEMY;
          ERASE_ENEMY: state_d = DRAW_ENEMY;
          DRAW_ENEMY: begin
            state_d      = IDLE;
            prevShipX_d  = newShipX_q;
            prevEnemyX_d = newEnemyX_q;
          end
          default:     state_d = IDLE;
        endcase
      end
    end
  end

  // Output register inputs: the pixel for the current state, or a quiet
  // bus while idle. done fires on the idle cycle that follows the last pixel.
  always_comb begin
    busy_d   = (state_q != IDLE);
    done_d   = (state_q == IDLE) && busy_o;
    plot_d   = 1'b0;
    x_d      = '0;
    y_d      = '0;
    colour_d = 3'b000;
    if (state_q != IDLE) begin
      plot_d   = (xSum < SCREEN_W9);
      x_d      = xSum[7:0];
      y_d      = baseY + 7'(dy_q);
      colour_d = pixColour;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer
//   Scoreboard bench for sprite_renderer. Each accepted request pushes the
//   whole expected per-cycle output sequence of one frame (quiet cycle,
//   128 pixels, done cycle) onto a queue; the bench then pops one entry per
//   cycle on the falling edge and compares it with the DUT outputs.
module tb_sprite_renderer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] user_x;
  logic [7:0] enemy_x;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;

  typedef struct {
    int         kind;   // 0 quiet, 1 pixel, 2 done
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       plot;
  } exp_t;

  exp_t sbQ[$];

  int vectors     = 0;
  int miscompares = 0;
  int prevShip    = 0;
  int prevEnemy   = 0;
  int shipPlots   = 0;
  int doneSeen    = 0;

  sprite_renderer dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .user_x_i  (user_x),
    .enemy_x_i (enemy_x),
    .busy_o    (busy),
    .done_o    (done),
    .x_out_o   (x_out),
    .y_out_o   (y_out),
    .colour_o  (colour),
    .plot_o    (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cycle-by-cycle stream for one frame, built from the bench's
  // own copy of the previously drawn positions.
  task automatic pushFrame(input int ux, input int ex);
    exp_t e;
    int   base, yTop, sum;
    logic [2:0] col;
    e.kind = 0; e.x = '0; e.y = '0; e.col = '0; e.plot = 1'b0;
    sbQ.push_back(e);
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin base = prevShip;  yTop = 116; col = 3'b000; end
        1: begin base = ux;        yTop = 116; col = 3'b010; end
        2: begin base = prevEnemy; yTop = 0;   col = 3'b000; end
        default: begin base = ex;  yTop = 0;   col = 3'b100; end
      endcase
      for (int dy = 0; dy < 4; dy++) begin
        for (int dx = 0; dx < 8; dx++) begin
          sum    = base + dx;
          e.kind = 1;
          e.x    = sum[7:0];
          e.y    = 7'(yTop + dy);
          e.col  = col;
          e.plot = (sum < 160);
          sbQ.push_back(e);
        end
      end
    end
    e.kind = 2; e.x = '0; e.y = '0; e.col = '0; e.plot = 1'b0;
    sbQ.push_back(e);
    prevShip  = ux;
    prevEnemy = ex;
  endtask

  // Pops and compares up to maxCycles entries, one per falling edge.
  task automatic drainQueue(input int maxCycles);
    exp_t e;
    int   n;
    n = 0;
    while (sbQ.size() > 0 && n < maxCycles) begin
      @(negedge clk);
      e = sbQ.pop_front();
      n++;
      vectors++;
      if (plot && colour == 3'b010) shipPlots++;
      if (done) doneSeen++;
      case (e.kind)
        0: if ({busy, done, plot} !== 3'b000) begin
             miscompares++;
             $display("[TB] FAIL quiet: busy/done/plot=%b required 000", {busy, done, plot});
           end
        2: if ({busy, done, plot} !== 3'b010) begin
             miscompares++;
             $display("[TB] FAIL done_cycle: busy/done/plot=%b required 010", {busy, done, plot});
           end
        default:
           if ({busy, done, plot, x_out, y_out, colour} !== {1'b1, 1'b0, e.plot, e.x, e.y, e.col}) begin
             miscompares++;
             $display("[TB] FAIL pixel: got busy=%b done=%b plot=%b x=%0d y=%0d col=%b required busy=1 done=0 plot=%b x=%0d y=%0d col=%b",
                      busy, done, plot, x_out, y_out, colour, e.plot, e.x, e.y, e.col);
           end
      endcase
    end
  endtask

  // Drives one start pulse sampled on a single rising edge.
  task automatic startFrame(input int ux, input int ex);
    @(negedge clk);
    user_x  = 8'(ux);
    enemy_x = 8'(ex);
    start   = 1'b1;
    pushFrame(ux, ex);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({busy, done, plot, x_out, y_out, colour} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {busy, done, plot, x_out, y_out, colour});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, plot} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: busy/done/plot=%b required 000", {busy, done, plot});
    end
  endtask

  task automatic test_first_frame();
    startFrame(10, 50);
    drainQueue(200);
  endtask

  task automatic test_prev_update();
    startFrame(12, 50);
    drainQueue(200);
  endtask

  task automatic test_clipping();
    shipPlots = 0;
    startFrame(155, 50);
    drainQueue(200);
    vectors++;
    if (shipPlots !== 20) begin
      miscompares++;
      $display("[TB] FAIL clip_ship_plots: got %0d required 20", shipPlots);
    end
  endtask

  task automatic test_back_to_back();
    doneSeen = 0;
    @(negedge clk);
    user_x  = 8'd20;
    enemy_x = 8'd60;
    start   = 1'b1;
    for (int f = 0; f < 3; f++) pushFrame(20, 60);
    @(posedge clk);
    drainQueue(500);
    start = 1'b0;
    vectors++;
    if (doneSeen !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_count: got %0d required 3", doneSeen);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, plot} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL b2b_stop: busy/done/plot=%b required 000", {busy, done, plot});
    end
  endtask

  task automatic test_midframe_input();
    startFrame(30, 80);
    fork
      drainQueue(200);
      begin
        repeat (60) @(posedge clk);
        #1;
        user_x  = 8'd99;
        enemy_x = 8'd7;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
  endtask

  task automatic test_reset_midframe();
    doneSeen = 0;
    startFrame(40, 70);
    drainQueue(41);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, plot, x_out, y_out, colour} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h required 0", {busy, done, plot, x_out, y_out, colour});
    end
    sbQ.delete();
    prevShip  = 0;
    prevEnemy = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (135) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    vectors++;
    if (doneSeen !== 0) begin
      miscompares++;
      $display("[TB] FAIL no_done_after_reset: got %0d required 0", doneSeen);
    end
    startFrame(5, 100);
    drainQueue(200);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    user_x  = '0;
    enemy_x = '0;
    $display("[TB] sprite_renderer bench starting");
    test_reset();
    test_first_frame();
    test_prev_update();
    test_clipping();
    test_back_to_back();
    test_midframe_input();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
